// File: rtl/mod_add64_pipe.sv
// Two-stage pipelined modular adder/subtractor for the R16 butterfly.
// Optional range flag: define MODADD_RANGE_CHK_EN to add range_err.
module mod_add64_pipe #(
  parameter int              WIDTH   = 64,
  parameter logic [WIDTH-1:0] MODULUS = 64'hFFFF_FFFF_0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MODADD_RANGE_CHK_EN
  output logic             range_err,
`endif
  output logic [WIDTH-1:0] result
);

  logic             s1_valid;
  logic             s1_sub;
  logic [WIDTH:0]   s1_raw;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;

  logic             in_fire;
  logic             s2_load;
  logic [WIDTH:0]   raw_next;
  logic [WIDTH-1:0] raw_lo;
  logic             raw_top;
  logic             need_fix;
  logic [WIDTH-1:0] fixed;
  logic [WIDTH-1:0] corr_res;

  // S2 takes a new beat when it is empty or its current beat leaves
  assign s2_load  = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign in_fire  = in_valid & in_ready;

  // Raw 65-bit sum, or two's-complement difference with carry = !borrow
  always_comb begin
    raw_next = '0;
    if (op_sub)
      raw_next = {1'b0, a} + {1'b0, ~b}
               + {{WIDTH{1'b0}}, 1'b1};
    else
      raw_next = {1'b0, a} + {1'b0, b};
  end

  // S1 register: holds a raw beat until S2 can take it
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sub   <= 1'b0;
      s1_raw   <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_sub   <= op_sub;
        s1_raw   <= raw_next;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign raw_lo  = s1_raw[WIDTH-1:0];
  assign raw_top = s1_raw[WIDTH];

  // Single conditional correction by p, from registered S1 state only
  always_comb begin
    need_fix = 1'b0;
    fixed    = raw_lo;
    if (s1_sub) begin
      need_fix = ~raw_top;
      fixed    = raw_lo + MODULUS;
    end else begin
      need_fix = raw_top | (raw_lo >= MODULUS);
      fixed    = raw_lo - MODULUS;
    end
    corr_res = need_fix ? fixed : raw_lo;
  end

  // S2 register: output stage, held stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_res   <= corr_res;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_res;

`ifdef MODADD_RANGE_CHK_EN
  logic s1_rerr;
  logic s2_rerr;
  logic rerr_next;

  assign rerr_next = (a >= MODULUS) | (b >= MODULUS);

  // Out-of-range flag travels alongside its beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rerr <= 1'b0;
      s2_rerr <= 1'b0;
    end else begin
      if (in_fire) s1_rerr <= rerr_next;
      if (s2_load) s2_rerr <= s1_rerr;
    end
  end

  assign range_err = s2_rerr;
`endif

endmodule

// File: tb/tb_mod_add64_pipe.sv
// Self-checking bench for mod_add64_pipe.
// Directed plan steps followed by a randomized scoreboard stream.
module tb_mod_add64_pipe;

  localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
`ifdef MODADD_RANGE_CHK_EN
  logic        range_err;
  bit          s_rerr;
  bit          rq[$];
`endif

  int          cmp = 0;
  int          err = 0;
  bit          s_acc;
  bit          s_drn;
  bit          s_rdy;
  logic [63:0] s_res;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  always #5 clk = ~clk;

  mod_add64_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MODADD_RANGE_CHK_EN
    .range_err (range_err),
`endif
    .result    (result)
  );

  function automatic logic [63:0] model(logic [63:0] x,
                                        logic [63:0] y,
                                        bit sub);
    logic [64:0] s;
    if (!sub) begin
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
      return s[63:0];
    end
    if (x >= y) return x - y;
    return x - y + P;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    cmp++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Samples handshakes just before the edge and keeps the scoreboard
  task automatic step();
    logic [63:0] e;
    #1;
    s_acc = in_valid & in_ready;
    s_drn = out_valid & out_ready;
    s_rdy = in_ready;
    s_res = result;
`ifdef MODADD_RANGE_CHK_EN
    s_rerr = range_err;
`endif
    if (rst) begin
      exp_q.delete();
`ifdef MODADD_RANGE_CHK_EN
      rq.delete();
`endif
    end else begin
      if (s_drn) begin
        cmp++;
        assert (exp_q.size() != 0) else begin
          err++;
          $error("FAIL drain_extra got=%h exp=none", result);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("drain", result, e);
          got_q.push_back(result);
`ifdef MODADD_RANGE_CHK_EN
          chk("drain_rerr", 64'(range_err), 64'(rq.pop_front()));
`endif
        end
      end
      if (s_acc) begin
        exp_q.push_back(model(a, b, op_sub));
`ifdef MODADD_RANGE_CHK_EN
        rq.push_back((a >= P) || (b >= P));
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic run1(string tag, logic [63:0] ta, logic [63:0] tb,
                      bit tsub, logic [63:0] texp, output int lat);
    a = ta; b = tb; op_sub = tsub; in_valid = 1'b1;
    step();
    chk({tag, "_acc"}, 64'(s_acc), 64'd1);
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (s_drn) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(s_drn), 64'd1);
    chk(tag, s_res, texp);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return P - 64'd1;
      2: return P;
      3: return v;
      default: return v % P;
    endcase
  endfunction

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0;
    a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    run1("add_5_7", 64'd5, 64'd7, 1'b0, 64'd12, lat);
    chk("latency", 64'(lat), 64'd2);
    run1("wrap", P - 64'd1, 64'd1, 1'b0, 64'd0, lat);
    run1("carry", P - 64'd1, P - 64'd1, 1'b0,
         64'hFFFF_FFFE_FFFF_FFFF, lat);
    run1("sub_borrow", 64'd3, 64'd5, 1'b1,
         64'hFFFF_FFFE_FFFF_FFFF, lat);
    run1("sub_9_4", 64'd9, 64'd4, 1'b1, 64'd5, lat);
    run1("sub_eq", 64'h1234_5678_9ABC_DEF0,
         64'h1234_5678_9ABC_DEF0, 1'b1, 64'd0, lat);
`ifdef MODADD_RANGE_CHK_EN
    run1("rng_p", P, 64'd0, 1'b0, 64'd0, lat);
    chk("rng_p_err", 64'(s_rerr), 64'd1);
    run1("rng_pm1", P - 64'd1, 64'd0, 1'b0, P - 64'd1, lat);
    chk("rng_pm1_err", 64'(s_rerr), 64'd0);
`endif

    // Backpressure: two beats fill the pipe, third is held off
    got_q.delete();
    out_ready = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    a = 64'd1; b = 64'd1;
    step();
    chk("bp_acc1", 64'(s_acc), 64'd1);
    a = 64'd2; b = 64'd2;
    step();
    chk("bp_acc2", 64'(s_acc), 64'd1);
    a = 64'd3; b = 64'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_in_ready", 64'(s_rdy), 64'd0);
      chk("bp_stable", s_res, 64'd2);
    end
    out_ready = 1'b1;
    step();
    chk("bp_acc3", 64'(s_acc), 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && got_q.size() < 3; i++) step();
    chk("bp_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() >= 3) begin
      chk("bp_order0", got_q[0], 64'd2);
      chk("bp_order1", got_q[1], 64'd4);
      chk("bp_order2", got_q[2], 64'd6);
    end

    // Reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1; op_sub = 1'b0;
    a = 64'd10; b = 64'd20;
    step();
    a = 64'd30; b = 64'd40;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    got_q.delete();
    repeat (4) step();
    chk("mid_rst_ghost", 64'(got_q.size()), 64'd0);

    // Random stream against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op_sub    = $urandom_range(0, 1) == 1;
      a = rnd_op();
      b = rnd_op();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
